// File: rtl/ov7620_capture_ctrl.sv
// OV7620 single-frame capture sequencer: waits for a full frame boundary, then writes a
// rectangular pixel window to the frame buffer in raster order.
module ov7620_capture_ctrl #(
  parameter int COL_START = 160,
  parameter int COLS      = 320,
  parameter int ROW_START = 120,
  parameter int ROWS      = 240,
  parameter int ADDR_W    = 17
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start_Sig,
  input  logic              VSYNC_Sig,
  input  logic              HREF_Sig,
  input  logic              PCLK_En,
  input  logic [7:0]        Pixel_Data,
  output logic              Wr_En,
  output logic [ADDR_W-1:0] Wr_Addr,
  output logic [7:0]        Wr_Data,
  output logic              Busy_Sig,
  output logic              Done_Sig,
  output logic              Frame_Err
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_WAIT_VS     = 3'd1;
  localparam logic [2:0] S_WAIT_VS_END = 3'd2;
  localparam logic [2:0] S_CAPTURE     = 3'd3;
  localparam logic [2:0] S_DONE        = 3'd4;

  localparam logic [10:0] LP_COL_LO = 11'(COL_START);
  localparam logic [10:0] LP_COL_HI = 11'(COL_START + COLS);
  localparam logic [10:0] LP_ROW_LO = 11'(ROW_START);
  localparam logic [10:0] LP_ROW_HI = 11'(ROW_START + ROWS);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(ROWS * COLS - 1);

  logic [2:0]        r_state;
  logic              r_vs_d, r_href_d;
  logic [9:0]        r_col_cnt, r_row_cnt;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_cap;
  logic [7:0]        r_pix;

  logic       w_vs_rise, w_vs_fall, w_href_rise, w_href_fall;
  logic [9:0] w_col_idx;
  logic       w_cap, w_last_wr, w_start_acc, w_err_set;
  logic [2:0] w_state_nxt;

  assign w_vs_rise   = VSYNC_Sig & ~r_vs_d;
  assign w_vs_fall   = ~VSYNC_Sig & r_vs_d;
  assign w_href_rise = HREF_Sig & ~r_href_d;
  assign w_href_fall = ~HREF_Sig & r_href_d;

  // A pixel arriving on the HREF rising edge is index 0 even though the counter hasn't cleared yet.
  assign w_col_idx = w_href_rise ? 10'd0 : r_col_cnt;

  assign w_cap = (r_state == S_CAPTURE) && PCLK_En && HREF_Sig &&
                 ({1'b0, w_col_idx} >= LP_COL_LO) && ({1'b0, w_col_idx} < LP_COL_HI) &&
                 ({1'b0, r_row_cnt} >= LP_ROW_LO) && ({1'b0, r_row_cnt} < LP_ROW_HI);

  assign w_last_wr   = Wr_En && (Wr_Addr == LP_LAST);
  assign w_start_acc = (r_state == S_IDLE) && Start_Sig;

  always_comb begin
    w_state_nxt = r_state;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE:        if (Start_Sig) w_state_nxt = S_WAIT_VS;
      S_WAIT_VS:     if (w_vs_rise) w_state_nxt = S_WAIT_VS_END;
      S_WAIT_VS_END: if (w_vs_fall) w_state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        // Completing the last write wins over a coincident VSYNC rise.
        if (w_last_wr) begin
          w_state_nxt = S_DONE;
        end else if (w_vs_rise) begin
          w_state_nxt = S_DONE;
          w_err_set   = 1'b1;
        end
      end
      S_DONE:        w_state_nxt = S_IDLE;
      default:       w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_vs_d    <= 1'b0;
      r_href_d  <= 1'b0;
      r_col_cnt <= '0;
      r_row_cnt <= '0;
      r_ptr     <= '0;
      r_cap     <= 1'b0;
      r_pix     <= '0;
      Wr_En     <= 1'b0;
      Wr_Addr   <= '0;
      Wr_Data   <= '0;
      Busy_Sig  <= 1'b0;
      Done_Sig  <= 1'b0;
      Frame_Err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      Busy_Sig <= (w_state_nxt != S_IDLE);
      Done_Sig <= (w_state_nxt == S_DONE);
      r_vs_d   <= VSYNC_Sig;
      r_href_d <= HREF_Sig;

      if (w_href_rise)
        r_col_cnt <= {9'd0, PCLK_En};
      else if (PCLK_En && HREF_Sig && r_col_cnt != 10'h3FF)
        r_col_cnt <= r_col_cnt + 10'd1;

      if (w_start_acc || (r_state == S_WAIT_VS_END && w_vs_fall))
        r_row_cnt <= '0;
      else if (r_state == S_CAPTURE && w_href_fall && r_row_cnt != 10'h3FF)
        r_row_cnt <= r_row_cnt + 10'd1;

      // Two-stage write path; an in-flight pixel drains even if the FSM has left CAPTURE.
      r_cap <= w_cap;
      if (w_cap) r_pix <= Pixel_Data;
      Wr_En <= r_cap;

      if (w_start_acc) begin
        Frame_Err <= 1'b0;
        Wr_Addr   <= '0;
        r_ptr     <= '0;
      end else if (r_cap) begin
        Wr_Addr <= r_ptr;
        Wr_Data <= r_pix;
        r_ptr   <= r_ptr + 1'b1;
      end

      if (w_err_set) Frame_Err <= 1'b1;
    end
  end

endmodule
